// File: rtl/ysyx_23060136_forward_unit_pkg.sv
// Shared types and widths for the EXU1 operand forwarding unit.
// The slot record carries CSR fields; they are only populated when
// YSYX_23060136_CSR_FWD_EN is defined.
`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif

package ysyx_23060136_PKG;

    localparam int unsigned BITS_W     = `ysyx_23060136_BITS_W;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CSR_ADDR_W = 12;
    // Slot 0 is EXU2 (youngest), slot 1 is MEM, slot 2 is WB (oldest).
    localparam int unsigned NUM_SLOTS  = 3;

    typedef struct packed {
        logic                  valid;
        logic                  rd_wen;
        logic [REG_ADDR_W-1:0] rd;
        logic [BITS_W-1:0]     data;
        logic                  rdy;
        logic                  csr_wen;
        logic [CSR_ADDR_W-1:0] csr_addr;
        logic [BITS_W-1:0]     csr_data;
    } fwd_slot_t;

    // Turn a slot into a bubble while keeping its payload.
    function automatic fwd_slot_t slot_kill(input fwd_slot_t s);
        fwd_slot_t r;
        r       = s;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_23060136_forward_unit_match.sv
// Priority lookup of one source address over the three forwarding slots.
// Slot 0 is the youngest producer and wins over older ones.
`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif

module ysyx_23060136_FWD_MATCH
    import ysyx_23060136_PKG::*;
#(
    parameter int unsigned AddrW    = REG_ADDR_W,
    parameter bit          SkipZero = 1'b1
) (
    input  logic [NUM_SLOTS-1:0]             i_slot_en,
    input  logic [NUM_SLOTS-1:0][AddrW-1:0]  i_slot_addr,
    input  logic [NUM_SLOTS-1:0][BITS_W-1:0] i_slot_data,
    input  logic [NUM_SLOTS-1:0]             i_slot_rdy,
    input  logic [AddrW-1:0]                 i_src,
    output logic                             o_hit,
    output logic [BITS_W-1:0]                o_data,
    output logic                             o_rdy
);

    logic w_src_ok;

    // Scan oldest to youngest so the youngest matching slot is left standing.
    always_comb begin
        o_hit    = 1'b0;
        o_data   = '0;
        o_rdy    = 1'b1;
        w_src_ok = !(SkipZero && (i_src == '0));
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_src_ok && i_slot_en[i] && (i_slot_addr[i] == i_src)) begin
                o_hit  = 1'b1;
                o_data = i_slot_data[i];
                o_rdy  = i_slot_rdy[i];
            end
        end
    end

endmodule

// File: rtl/ysyx_23060136_forward_unit.sv
// EXU1 operand forwarding: tracks the producers sitting in EXU2/MEM/WB and
// supplies their results to the EXU1 instruction, stalling on pending loads.
// Optional CSR forwarding is enabled by defining YSYX_23060136_CSR_FWD_EN.
`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif

module ysyx_23060136_forward_unit
    import ysyx_23060136_PKG::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EXU1_valid,
    input  logic [REG_ADDR_W-1:0] EXU1_rs1,
    input  logic [REG_ADDR_W-1:0] EXU1_rs2,
    input  logic [CSR_ADDR_W-1:0] EXU1_csr_rs,
    input  logic                  EXU1_fire,
    input  logic                  EXU1_rd_wen,
    input  logic [REG_ADDR_W-1:0] EXU1_rd,
    input  logic                  EXU1_is_load,
    input  logic [BITS_W-1:0]     EXU1_result,
    input  logic                  EXU1_csr_wen,
    input  logic [CSR_ADDR_W-1:0] EXU1_csr_addr,
    input  logic [BITS_W-1:0]     EXU1_csr_wdata,
    input  logic                  EXU2_fire,
    input  logic                  MEM_fire,
    input  logic                  MEM_load_done,
    input  logic [BITS_W-1:0]     MEM_load_data,
    input  logic                  WB_fire,
    output logic [BITS_W-1:0]     FORWARD_rs1_data_EXU1,
    output logic [BITS_W-1:0]     FORWARD_rs2_data_EXU1,
    output logic [BITS_W-1:0]     FORWARD_csr_rs_data_EXU1,
    output logic                  FORWARD_rs1_hazard_EXU1,
    output logic                  FORWARD_rs2_hazard_EXU1,
    output logic                  FORWARD_csr_rs_hazard_EXU1,
    output logic                  FORWARD_stall_EXU1
);

    fwd_slot_t [NUM_SLOTS-1:0] r_slot;
    fwd_slot_t [NUM_SLOTS-1:0] w_slot_nxt;
    fwd_slot_t                 w_new;
    fwd_slot_t                 w_s1_upd;

    logic [NUM_SLOTS-1:0]                 w_gpr_en;
    logic [NUM_SLOTS-1:0][REG_ADDR_W-1:0] w_gpr_addr;
    logic [NUM_SLOTS-1:0][BITS_W-1:0]     w_gpr_data;
    logic [NUM_SLOTS-1:0]                 w_gpr_rdy;

    logic              w_rs1_hit, w_rs1_rdy, w_rs2_hit, w_rs2_rdy;
    logic [BITS_W-1:0] w_rs1_data, w_rs2_data;

    // Next slot contents from the pipeline handshakes and returning load data.
    always_comb begin
        // S1 with a returning load folded in; also what S2 captures on MEM_fire.
        w_s1_upd = r_slot[1];
        if (MEM_load_done && r_slot[1].valid && !r_slot[1].rdy) begin
            w_s1_upd.data = MEM_load_data;
            w_s1_upd.rdy  = 1'b1;
        end

        w_new        = '0;
        w_new.valid  = 1'b1;
        w_new.rd_wen = EXU1_rd_wen;
        w_new.rd     = EXU1_rd;
        w_new.data   = EXU1_result;
        w_new.rdy    = !EXU1_is_load;
`ifdef YSYX_23060136_CSR_FWD_EN
        w_new.csr_wen  = EXU1_csr_wen;
        w_new.csr_addr = EXU1_csr_addr;
        w_new.csr_data = EXU1_csr_wdata;
`endif

        w_slot_nxt = r_slot;

        if (EXU1_fire) begin
            w_slot_nxt[0] = w_new;
        end else if (EXU2_fire) begin
            w_slot_nxt[0] = slot_kill(r_slot[0]);
        end

        if (EXU2_fire) begin
            w_slot_nxt[1] = r_slot[0];
        end else if (MEM_fire) begin
            w_slot_nxt[1] = slot_kill(w_s1_upd);
        end else begin
            w_slot_nxt[1] = w_s1_upd;
        end

        if (MEM_fire) begin
            w_slot_nxt[2] = w_s1_upd;
        end else if (WB_fire) begin
            w_slot_nxt[2] = slot_kill(r_slot[2]);
        end
    end

    // Slot registers; reset drops valid/rdy only, payload is left as is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            r_slot[i] <= w_slot_nxt[i];
            if (rst) begin
                r_slot[i].valid <= 1'b0;
                r_slot[i].rdy   <= 1'b0;
            end
        end
    end

    // Flatten GPR producer fields for the lookup instances.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_gpr_en[i]   = r_slot[i].valid && r_slot[i].rd_wen;
            w_gpr_addr[i] = r_slot[i].rd;
            w_gpr_data[i] = r_slot[i].data;
            w_gpr_rdy[i]  = r_slot[i].rdy;
        end
    end

    ysyx_23060136_FWD_MATCH #(
        .AddrW    (REG_ADDR_W),
        .SkipZero (1'b1)
    ) u_match_rs1 (
        .i_slot_en   (w_gpr_en),
        .i_slot_addr (w_gpr_addr),
        .i_slot_data (w_gpr_data),
        .i_slot_rdy  (w_gpr_rdy),
        .i_src       (EXU1_rs1),
        .o_hit       (w_rs1_hit),
        .o_data      (w_rs1_data),
        .o_rdy       (w_rs1_rdy)
    );

    ysyx_23060136_FWD_MATCH #(
        .AddrW    (REG_ADDR_W),
        .SkipZero (1'b1)
    ) u_match_rs2 (
        .i_slot_en   (w_gpr_en),
        .i_slot_addr (w_gpr_addr),
        .i_slot_data (w_gpr_data),
        .i_slot_rdy  (w_gpr_rdy),
        .i_src       (EXU1_rs2),
        .o_hit       (w_rs2_hit),
        .o_data      (w_rs2_data),
        .o_rdy       (w_rs2_rdy)
    );

    assign FORWARD_rs1_data_EXU1   = w_rs1_data;
    assign FORWARD_rs2_data_EXU1   = w_rs2_data;
    assign FORWARD_rs1_hazard_EXU1 = EXU1_valid && w_rs1_hit;
    assign FORWARD_rs2_hazard_EXU1 = EXU1_valid && w_rs2_hit;
    assign FORWARD_stall_EXU1      = EXU1_valid &&
                                     ((w_rs1_hit && !w_rs1_rdy) || (w_rs2_hit && !w_rs2_rdy));

`ifdef YSYX_23060136_CSR_FWD_EN
    logic [NUM_SLOTS-1:0]                 w_csr_en;
    logic [NUM_SLOTS-1:0][CSR_ADDR_W-1:0] w_csr_addr;
    logic [NUM_SLOTS-1:0][BITS_W-1:0]     w_csr_data;
    logic                                 w_csr_hit, w_csr_rdy;

    // Flatten CSR producer fields; CSR writes carry their data from EXU1.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_csr_en[i]   = r_slot[i].valid && r_slot[i].csr_wen;
            w_csr_addr[i] = r_slot[i].csr_addr;
            w_csr_data[i] = r_slot[i].csr_data;
        end
    end

    ysyx_23060136_FWD_MATCH #(
        .AddrW    (CSR_ADDR_W),
        .SkipZero (1'b0)
    ) u_match_csr (
        .i_slot_en   (w_csr_en),
        .i_slot_addr (w_csr_addr),
        .i_slot_data (w_csr_data),
        .i_slot_rdy  ({NUM_SLOTS{1'b1}}),
        .i_src       (EXU1_csr_rs),
        .o_hit       (w_csr_hit),
        .o_data      (FORWARD_csr_rs_data_EXU1),
        .o_rdy       (w_csr_rdy)
    );

    assign FORWARD_csr_rs_hazard_EXU1 = EXU1_valid && w_csr_hit && w_csr_rdy;
`else
    logic w_unused_csr;
    assign w_unused_csr = ^{EXU1_csr_rs, EXU1_csr_wen, EXU1_csr_addr, EXU1_csr_wdata};

    assign FORWARD_csr_rs_hazard_EXU1 = 1'b0;
    assign FORWARD_csr_rs_data_EXU1   = '0;
`endif

`ifndef SYNTHESIS
    // Firing into a stall would hand EXU2 a stale operand.
    a_no_fire_on_stall : assert property (@(posedge clk) disable iff (rst)
        !(EXU1_fire && FORWARD_stall_EXU1))
        else $error("EXU1_fire asserted while FORWARD_stall_EXU1 is high");
`endif

endmodule

// File: tb/tb_ysyx_23060136_forward_unit.sv
// Bench for the forwarding unit: directed vector table, a reset-during-load
// sequence, and random traffic against an in-flight-instruction model.
module tb_ysyx_23060136_forward_unit;

`ifdef YSYX_23060136_CSR_FWD_EN
    localparam bit CsrEn = 1'b1;
`else
    localparam bit CsrEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        EXU1_valid;
    logic [4:0]  EXU1_rs1, EXU1_rs2;
    logic [11:0] EXU1_csr_rs;
    logic        EXU1_fire, EXU1_rd_wen, EXU1_is_load;
    logic [4:0]  EXU1_rd;
    logic [31:0] EXU1_result;
    logic        EXU1_csr_wen;
    logic [11:0] EXU1_csr_addr;
    logic [31:0] EXU1_csr_wdata;
    logic        EXU2_fire, MEM_fire, MEM_load_done, WB_fire;
    logic [31:0] MEM_load_data;
    logic [31:0] FORWARD_rs1_data_EXU1, FORWARD_rs2_data_EXU1, FORWARD_csr_rs_data_EXU1;
    logic        FORWARD_rs1_hazard_EXU1, FORWARD_rs2_hazard_EXU1, FORWARD_csr_rs_hazard_EXU1;
    logic        FORWARD_stall_EXU1;

    ysyx_23060136_forward_unit u_dut (
        .clk                        (clk),
        .rst                        (rst),
        .EXU1_valid                 (EXU1_valid),
        .EXU1_rs1                   (EXU1_rs1),
        .EXU1_rs2                   (EXU1_rs2),
        .EXU1_csr_rs                (EXU1_csr_rs),
        .EXU1_fire                  (EXU1_fire),
        .EXU1_rd_wen                (EXU1_rd_wen),
        .EXU1_rd                    (EXU1_rd),
        .EXU1_is_load               (EXU1_is_load),
        .EXU1_result                (EXU1_result),
        .EXU1_csr_wen               (EXU1_csr_wen),
        .EXU1_csr_addr              (EXU1_csr_addr),
        .EXU1_csr_wdata             (EXU1_csr_wdata),
        .EXU2_fire                  (EXU2_fire),
        .MEM_fire                   (MEM_fire),
        .MEM_load_done              (MEM_load_done),
        .MEM_load_data              (MEM_load_data),
        .WB_fire                    (WB_fire),
        .FORWARD_rs1_data_EXU1      (FORWARD_rs1_data_EXU1),
        .FORWARD_rs2_data_EXU1      (FORWARD_rs2_data_EXU1),
        .FORWARD_csr_rs_data_EXU1   (FORWARD_csr_rs_data_EXU1),
        .FORWARD_rs1_hazard_EXU1    (FORWARD_rs1_hazard_EXU1),
        .FORWARD_rs2_hazard_EXU1    (FORWARD_rs2_hazard_EXU1),
        .FORWARD_csr_rs_hazard_EXU1 (FORWARD_csr_rs_hazard_EXU1),
        .FORWARD_stall_EXU1         (FORWARD_stall_EXU1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected before the clock edge.
    typedef struct packed {
        logic        rst, v;
        logic [4:0]  rs1, rs2;
        logic [11:0] csr_rs;
        logic        e1f, wen;
        logic [4:0]  rd;
        logic        ld;
        logic [31:0] res;
        logic        cwen;
        logic [11:0] caddr;
        logic [31:0] cdata;
        logic        e2f, memf, ldd;
        logic [31:0] ldata;
        logic        wbf;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
        logic        hc;
        logic [31:0] dc;
        logic        st;
    } vec_t;

    // Reference model: a list of in-flight instructions tagged by stage.
    typedef struct {
        int          stage;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          rdy;
        logic        cwen;
        logic [11:0] caddr;
        logic [31:0] cdata;
    } ent_t;

    ent_t inflight[$];
    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic vec_t qry(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [11:0] csr_rs);
        vec_t t;
        t        = '0;
        t.v      = v;
        t.rs1    = rs1;
        t.rs2    = rs2;
        t.csr_rs = csr_rs;
        return t;
    endfunction

    function automatic vec_t ex(input vec_t t_in, input logic h1, input logic [31:0] d1,
                                input logic h2, input logic [31:0] d2, input logic hc,
                                input logic [31:0] dc, input logic st);
        vec_t t;
        t    = t_in;
        t.h1 = h1;
        t.d1 = d1;
        t.h2 = h2;
        t.d2 = d2;
        t.hc = hc;
        t.dc = dc;
        t.st = st;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst            = t.rst;
        EXU1_valid     = t.v;
        EXU1_rs1       = t.rs1;
        EXU1_rs2       = t.rs2;
        EXU1_csr_rs    = t.csr_rs;
        EXU1_fire      = t.e1f;
        EXU1_rd_wen    = t.wen;
        EXU1_rd        = t.rd;
        EXU1_is_load   = t.ld;
        EXU1_result    = t.res;
        EXU1_csr_wen   = t.cwen;
        EXU1_csr_addr  = t.caddr;
        EXU1_csr_wdata = t.cdata;
        EXU2_fire      = t.e2f;
        MEM_fire       = t.memf;
        MEM_load_done  = t.ldd;
        MEM_load_data  = t.ldata;
        WB_fire        = t.wbf;
    endtask

    task automatic check_all(input string tag, input vec_t t);
        chk({tag, ".rs1_hazard"}, {31'd0, FORWARD_rs1_hazard_EXU1}, {31'd0, t.h1});
        chk({tag, ".rs1_data"}, FORWARD_rs1_data_EXU1, t.d1);
        chk({tag, ".rs2_hazard"}, {31'd0, FORWARD_rs2_hazard_EXU1}, {31'd0, t.h2});
        chk({tag, ".rs2_data"}, FORWARD_rs2_data_EXU1, t.d2);
        chk({tag, ".csr_hazard"}, {31'd0, FORWARD_csr_rs_hazard_EXU1}, {31'd0, t.hc});
        chk({tag, ".csr_data"}, FORWARD_csr_rs_data_EXU1, t.dc);
        chk({tag, ".stall"}, {31'd0, FORWARD_stall_EXU1}, {31'd0, t.st});
    endtask

    // Apply for one cycle: drive at negedge, sample mid-low, advance to next negedge.
    task automatic step(input string tag, input vec_t t, input bit do_check);
        drive(t);
        #1;
        if (do_check) check_all(tag, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Youngest producer (lowest stage) writing rs; x0 never matches.
    function automatic void gpr_lookup(input logic [4:0] rs, output bit hit,
                                       output logic [31:0] data, output bit rdy);
        int best = 99;
        hit  = 1'b0;
        data = '0;
        rdy  = 1'b1;
        if (rs != 5'd0) begin
            foreach (inflight[k]) begin
                if (inflight[k].wen && inflight[k].rd == rs && inflight[k].stage < best) begin
                    best = inflight[k].stage;
                    hit  = 1'b1;
                    data = inflight[k].data;
                    rdy  = inflight[k].rdy;
                end
            end
        end
    endfunction

    function automatic void csr_lookup(input logic [11:0] a, output bit hit,
                                       output logic [31:0] data);
        int best = 99;
        hit  = 1'b0;
        data = '0;
        foreach (inflight[k]) begin
            if (inflight[k].cwen && inflight[k].caddr == a && inflight[k].stage < best) begin
                best = inflight[k].stage;
                hit  = 1'b1;
                data = inflight[k].cdata;
            end
        end
    endfunction

    function automatic vec_t model_expect(input vec_t t_in);
        vec_t        t;
        bit          h1, h2, hc, r1, r2;
        logic [31:0] d1, d2, dc;
        t = t_in;
        gpr_lookup(t.rs1, h1, d1, r1);
        gpr_lookup(t.rs2, h2, d2, r2);
        csr_lookup(t.csr_rs, hc, dc);
        t.h1 = t.v && h1;
        t.d1 = d1;
        t.h2 = t.v && h2;
        t.d2 = d2;
        t.hc = CsrEn && t.v && hc;
        t.dc = CsrEn ? dc : 32'd0;
        t.st = t.v && ((h1 && !r1) || (h2 && !r2));
        return t;
    endfunction

    // Move every in-flight instruction according to this cycle's handshakes.
    task automatic model_step(input vec_t t);
        ent_t nq[$];
        ent_t e;
        if (t.rst) begin
            inflight.delete();
            return;
        end
        foreach (inflight[k]) begin
            e = inflight[k];
            case (e.stage)
                0: begin
                    if (t.e2f) begin
                        e.stage = 1;
                        nq.push_back(e);
                    end else if (!t.e1f) begin
                        nq.push_back(e);
                    end
                end
                1: begin
                    if (t.ldd && !e.rdy) begin
                        e.data = t.ldata;
                        e.rdy  = 1'b1;
                    end
                    if (t.memf) begin
                        e.stage = 2;
                        nq.push_back(e);
                    end else if (!t.e2f) begin
                        nq.push_back(e);
                    end
                end
                default: if (!t.memf && !t.wbf) nq.push_back(e);
            endcase
        end
        if (t.e1f) begin
            e.stage = 0;
            e.wen   = t.wen;
            e.rd    = t.rd;
            e.data  = t.res;
            e.rdy   = !t.ld;
            e.cwen  = t.cwen;
            e.caddr = t.caddr;
            e.cdata = t.cdata;
            nq.push_back(e);
        end
        inflight = nq;
    endtask

    initial begin
        vec_t        t;
        logic [31:0] csr_d;
        csr_d = CsrEn ? 32'hABCD : 32'd0;

        // Directed sequence, one row per cycle.
        t = qry(1, 5, 7, 0); t.e1f = 1; t.wen = 1; t.rd = 5; t.res = 32'h10;
        vecs.push_back(ex(t, 0, 0, 0, 0, 0, 0, 0));
        t = qry(1, 5, 7, 0);
        vecs.push_back(ex(t, 1, 32'h10, 0, 0, 0, 0, 0));
        t = qry(1, 5, 7, 0); t.e1f = 1; t.wen = 1; t.rd = 7; t.ld = 1; t.e2f = 1;
        vecs.push_back(ex(t, 1, 32'h10, 0, 0, 0, 0, 0));
        t = qry(1, 5, 7, 0);
        vecs.push_back(ex(t, 1, 32'h10, 1, 0, 0, 0, 1));
        t = qry(1, 5, 7, 0); t.e2f = 1; t.memf = 1;
        vecs.push_back(ex(t, 1, 32'h10, 1, 0, 0, 0, 1));
        t = qry(1, 5, 7, 0); t.ldd = 1; t.ldata = 32'hDEAD;
        vecs.push_back(ex(t, 1, 32'h10, 1, 0, 0, 0, 1));
        t = qry(1, 5, 7, 0);
        vecs.push_back(ex(t, 1, 32'h10, 1, 32'hDEAD, 0, 0, 0));
        t = qry(1, 5, 7, 0); t.e1f = 1; t.wen = 1; t.rd = 3; t.res = 32'h1;
        t.e2f = 1; t.memf = 1; t.wbf = 1;
        vecs.push_back(ex(t, 1, 32'h10, 1, 32'hDEAD, 0, 0, 0));
        t = qry(1, 3, 7, 0); t.e2f = 1;
        vecs.push_back(ex(t, 1, 32'h1, 1, 32'hDEAD, 0, 0, 0));
        t = qry(1, 3, 7, 0); t.e1f = 1; t.wen = 1; t.rd = 3; t.res = 32'h2; t.memf = 1;
        vecs.push_back(ex(t, 1, 32'h1, 1, 32'hDEAD, 0, 0, 0));
        t = qry(1, 3, 0, 0); t.e1f = 1; t.wen = 1; t.rd = 0; t.res = 32'h55; t.e2f = 1;
        vecs.push_back(ex(t, 1, 32'h2, 0, 0, 0, 0, 0));
        t = qry(1, 0, 3, 0); t.e1f = 1; t.cwen = 1; t.caddr = 12'h300;
        t.cdata = 32'hABCD; t.e2f = 1;
        vecs.push_back(ex(t, 0, 0, 1, 32'h2, 0, 0, 0));
        t = qry(1, 3, 0, 12'h300);
        vecs.push_back(ex(t, 1, 32'h1, 0, 0, CsrEn, csr_d, 0));
        t = qry(0, 3, 0, 12'h300);
        vecs.push_back(ex(t, 0, 32'h1, 0, 0, 0, csr_d, 0));
        t = qry(1, 3, 0, 12'h301); t.wbf = 1;
        vecs.push_back(ex(t, 1, 32'h1, 0, 0, 0, 0, 0));
        t = qry(1, 3, 0, 12'h300);
        vecs.push_back(ex(t, 0, 0, 0, 0, CsrEn, csr_d, 0));

        t = '0; t.rst = 1;
        drive(t);
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i], 1'b1);

        // Reset while a load waits in MEM, then a stale load return.
        t = '0; t.rst = 1;
        step("rstseq.clr", t, 1'b0);
        t = qry(1, 9, 0, 0); t.e1f = 1; t.wen = 1; t.rd = 9; t.ld = 1;
        step("rstseq.fire", ex(t, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        t = qry(1, 9, 0, 0); t.e2f = 1;
        step("rstseq.s0", ex(t, 1, 0, 0, 0, 0, 0, 1), 1'b1);
        t = qry(1, 9, 0, 0); t.rst = 1;
        step("rstseq.s1", ex(t, 1, 0, 0, 0, 0, 0, 1), 1'b1);
        t = qry(1, 9, 9, 0); t.ldd = 1; t.ldata = 32'hBEEF; t.memf = 1;
        step("rstseq.after", ex(t, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        t = qry(1, 9, 9, 0);
        step("rstseq.late", ex(t, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        // Random traffic against the model, starting from a clean reset.
        t = '0; t.rst = 1;
        step("rnd.rst", t, 1'b0);
        inflight.delete();
        for (int n = 0; n < 3000; n++) begin
            t        = '0;
            t.rst    = ($urandom_range(0, 99) == 0);
            t.v      = ($urandom_range(0, 3) != 0);
            t.rs1    = 5'($urandom_range(0, 7));
            t.rs2    = 5'($urandom_range(0, 7));
            t.csr_rs = 12'h300 + 12'($urandom_range(0, 3));
            t        = model_expect(t);
            t.e1f    = t.v && !t.st && ($urandom_range(0, 1) == 1);
            t.wen    = ($urandom_range(0, 3) != 0);
            t.rd     = 5'($urandom_range(0, 7));
            t.ld     = ($urandom_range(0, 2) == 0);
            t.res    = $urandom;
            t.cwen   = ($urandom_range(0, 2) == 0);
            t.caddr  = 12'h300 + 12'($urandom_range(0, 3));
            t.cdata  = $urandom;
            t.e2f    = ($urandom_range(0, 1) == 1);
            t.memf   = ($urandom_range(0, 1) == 1);
            t.wbf    = ($urandom_range(0, 1) == 1);
            t.ldd    = ($urandom_range(0, 2) == 0);
            t.ldata  = $urandom;
            drive(t);
            #1;
            check_all($sformatf("rnd%0d", n), t);
            @(posedge clk);
            model_step(t);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_23060136_forward_unit.md
YSYX_23060136_FORWARD_UNIT -- requirements
Module: ysyx_23060136_FORWARD_UNIT

Interface
REQ-001 No parameters; widths come from `ysyx_23060136_BITS_W (data, 32) and shared package constants (reg addr 5, CSR addr 12).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 EXU1_valid  in  1  EXU1 holds a valid instruction.
REQ-005 EXU1_rs1 / EXU1_rs2  in  5 each  source register addresses of the EXU1 instruction.
REQ-006 EXU1_csr_rs  in  12  CSR source address of the EXU1 instruction.
REQ-007 EXU1_fire  in  1  EXU1 instruction advances into EXU2 this cycle.
REQ-008 EXU1_rd_wen / EXU1_rd  in  1 / 5  GPR write enable / destination of the firing instruction.
REQ-009 EXU1_is_load  in  1  firing instruction is a load; its result is not ready.
REQ-010 EXU1_result  in  BITS_W  ALU result of the firing instruction.
REQ-011 EXU1_csr_wen / EXU1_csr_addr / EXU1_csr_wdata  in  1 / 12 / BITS_W  CSR write of the firing instruction.
REQ-012 EXU2_fire  in  1  EXU2 contents advance to MEM.
REQ-013 MEM_fire  in  1  MEM contents advance to WB.
REQ-014 MEM_load_done / MEM_load_data  in  1 / BITS_W  load data returned for the MEM-stage instruction.
REQ-015 WB_fire  in  1  WB instruction retires.
REQ-016 FORWARD_rs1_data_EXU1 / FORWARD_rs2_data_EXU1 / FORWARD_csr_rs_data_EXU1  out  BITS_W  forwarded values.
REQ-017 FORWARD_rs1_hazard_EXU1 / FORWARD_rs2_hazard_EXU1 / FORWARD_csr_rs_hazard_EXU1  out  1  forwarded value must replace the register-file value.
REQ-018 FORWARD_stall_EXU1  out  1  a matching producer's data is not ready; EXU1 must not fire.

Function
REQ-019 Three slots S0 (EXU2), S1 (MEM), S2 (WB). Each slot holds valid, rd_wen, rd, data, rdy, csr_wen, csr_addr, csr_data.
REQ-020 S0 update: EXU1_fire loads S0 from the EXU1 inputs with rdy = !EXU1_is_load; else EXU2_fire clears S0.valid; else S0 holds.
REQ-021 S1 update: EXU2_fire loads S1 from S0 (an invalid S0 propagates as a bubble); else MEM_fire clears S1.valid; else S1 holds.
REQ-022 S2 update: MEM_fire loads S2 from S1; else WB_fire clears S2.valid. MEM_fire and WB_fire in the same cycle: the load from S1 wins.
REQ-023 MEM_load_done with S1 valid and !rdy sets S1.data = MEM_load_data and rdy = 1. If MEM_fire occurs in the same cycle, S2 captures MEM_load_data with rdy = 1.
REQ-024 GPR match for rsX: slot valid, rd_wen, rd == rsX, rsX != 0. Priority is S0 > S1 > S2 (youngest wins).
REQ-025 hazard_rsX = EXU1_valid AND any GPR match. data_rsX = data of the winning slot, else 0.
REQ-026 Outputs are combinational from slot state. A producer fired at cycle N is matchable from cycle N+1 onward.
REQ-027 FORWARD_stall_EXU1 = EXU1_valid AND (rs1 or rs2 winning slot has rdy = 0). While stalled, the hazard flags still assert.
REQ-028 CSR match: slot valid, csr_wen, csr_addr == EXU1_csr_rs, with the same S0 > S1 > S2 priority. CSR data is always ready and never stalls.
REQ-029 EXU1_fire while FORWARD_stall_EXU1 = 1 is illegal and is flagged by a simulation-only assertion.

Reset
REQ-030 rst clears all slot valid and rdy bits in the next cycle, including mid-load, so all hazard and stall outputs read 0 after the reset edge. Data fields are not reset.

Configuration
REQ-031 With YSYX_23060136_CSR_FWD_EN defined, CSR slot fields are stored and CSR forwarding behaves per REQ-028. Without it, CSR fields are not stored, FORWARD_csr_rs_hazard_EXU1 = 0, and FORWARD_csr_rs_data_EXU1 = 0.

Structure
REQ-032 The slot struct typedef fwd_slot_t and the constants REG_ADDR_W = 5 and CSR_ADDR_W = 12 live in the shared package ysyx_23060136_PKG.
REQ-033 Sub-module ysyx_23060136_FWD_MATCH performs the priority lookup over the three slots for one source. It is instantiated for rs1, rs2 and csr (the csr instance only under YSYX_23060136_CSR_FWD_EN).

Verification
REQ-034 Fire addi rd=5, result 0x10; next cycle EXU1_rs1 = 5 -> rs1 hazard = 1, data = 0x10, stall = 0.
REQ-035 Fire a load with rd=7; EXU1_rs2 = 7 -> stall = 1 until MEM_load_done with 0xDEAD; the following cycle gives rs2 data = 0xDEAD and stall = 0.
REQ-036 rd=3 in S2 with 0x1 and in S0 with 0x2; EXU1_rs1 = 3 -> data = 0x2 (youngest wins). rs1 = 0 with rd=0 in flight -> hazard = 0.
REQ-037 CSR write to 0x300 with 0xABCD, then EXU1_csr_rs = 0x300 -> csr hazard = 1, data = 0xABCD. With the macro undefined -> hazard = 0, data = 0.
REQ-038 Assert rst while a load is pending in S1 -> next cycle all hazard and stall outputs = 0; a later MEM_load_done has no effect.
